// File: rtl/mem_loader_pkg.sv
// Shared types and default sizes for the memory-initialization boot loader.
package mem_loader_pkg;

    // Default memory depths in 32-bit words; must track the core's memory sizing.
    localparam int IM_DEPTH_DEF = 256;
    localparam int SM_DEPTH_DEF = 256;

    // Frame header opcodes (header bits [1:0]; bits [7:2] are ignored).
    typedef enum logic [1:0] {
        OP_LOAD_IM = 2'b00,
        OP_LOAD_SM = 2'b01,
        OP_RUN     = 2'b10,
        OP_HALT    = 2'b11
    } opcode_e;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_init_loader_byte_word_packer.sv
// Assembles four bytes, least significant first, into a 32-bit word.
// o_word already includes the byte being accepted, so the caller can use
// the complete word in the same cycle that o_word_valid is high.
module byte_word_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic [31:0] w_word;

    // New bytes enter at the top; after four shifts the first byte sits in [7:0].
    assign w_word       = {i_byte, r_word[31:8]};
    assign o_word       = w_word;
    assign o_word_valid = i_en && !i_clear && (r_byte_idx == 2'd3);

    // Shift register and byte position; clear drops any partial word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
        end else if (i_clear) begin
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
        end else if (i_en) begin
            r_word     <= w_word;
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/mem_init_loader.sv
// Byte-stream boot loader driving the IM/SM initialization write ports.
// Stream handshake: a byte moves when in_valid && in_ready on a rising clock
// edge; the host may drop in_valid at any time and the loader just waits.
// in_ready is registered: high in IDLE/CNT_LO/CNT_HI/DATA, low in WRITE and reset.
module mem_init_loader
    import mem_loader_pkg::*;
#(
    parameter  int IM_DEPTH = IM_DEPTH_DEF,
    parameter  int SM_DEPTH = SM_DEPTH_DEF,
    localparam int IM_AW    = $clog2(IM_DEPTH << 2),
    localparam int SM_AW    = $clog2(SM_DEPTH << 2)
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IM_AW-1:0] writeAddr_IM,
    output logic [31:0]      writeData_IM,
    output logic             writeEn_IM,
    output logic [SM_AW-1:0] writeAddr_SM_TB,
    output logic [31:0]      writeData_SM_TB,
    output logic             writeEn_SM_TB,
    output logic             Memory_Initialization,
    output logic             load_done,
    output logic             err_overflow
);

    localparam logic [16:0] IM_DEPTH_W = 17'(IM_DEPTH);
    localparam logic [16:0] SM_DEPTH_W = 17'(SM_DEPTH);

    state_e      r_state;
    logic        r_in_ready;
    logic        r_is_sm;
    logic [15:0] r_cnt;
    logic [15:0] r_idx;
    logic        r_mem_init;
    logic        r_load_done;
    logic        r_err;
    logic        r_we_im;
    logic        r_we_sm;
    logic [IM_AW-1:0] r_addr_im;
    logic [SM_AW-1:0] r_addr_sm;
    logic [31:0] r_data_im;
    logic [31:0] r_data_sm;

    logic        w_accept;
    opcode_e     w_opcode;
    logic        w_pk_clear;
    logic        w_pk_en;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic        w_in_range;
    logic        w_last;

    assign w_accept   = in_valid && r_in_ready;
    assign w_opcode   = opcode_e'(in_data[1:0]);
    assign w_pk_clear = (r_state == ST_CNT_HI) && w_accept;
    assign w_pk_en    = (r_state == ST_DATA) && w_accept;
    assign w_in_range = r_is_sm ? ({1'b0, r_idx} < SM_DEPTH_W)
                                : ({1'b0, r_idx} < IM_DEPTH_W);
    assign w_last     = ((r_idx + 16'd1) == r_cnt);

    byte_word_packer u_packer (
        .i_clk        (clk_100MHz),
        .i_rst_n      (reset),
        .i_clear      (w_pk_clear),
        .i_en         (w_pk_en),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Frame FSM with registered strobes: the write is launched when the 4th
    // byte is accepted so the strobe is visible during the WRITE cycle.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_is_sm     <= 1'b0;
            r_cnt       <= 16'd0;
            r_idx       <= 16'd0;
            r_mem_init  <= 1'b1;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_we_im     <= 1'b0;
            r_we_sm     <= 1'b0;
            r_addr_im   <= '0;
            r_addr_sm   <= '0;
            r_data_im   <= 32'd0;
            r_data_sm   <= 32'd0;
        end else begin
            r_load_done <= 1'b0;
            r_we_im     <= 1'b0;
            r_we_sm     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        unique case (w_opcode)
                            OP_LOAD_IM, OP_LOAD_SM: begin
                                r_is_sm    <= (w_opcode == OP_LOAD_SM);
                                r_idx      <= 16'd0;
                                r_err      <= 1'b0;
                                r_mem_init <= 1'b1;
                                r_state    <= ST_CNT_LO;
                            end
                            OP_RUN:  r_mem_init <= 1'b0;
                            OP_HALT: r_mem_init <= 1'b1;
                        endcase
                    end
                end
                ST_CNT_LO: begin
                    if (w_accept) begin
                        r_cnt[7:0] <= in_data;
                        r_state    <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (w_accept) begin
                        r_cnt[15:8] <= in_data;
                        if ({in_data, r_cnt[7:0]} == 16'd0) begin
                            r_load_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_valid) begin
                        r_in_ready <= 1'b0;
                        r_state    <= ST_WRITE;
                        if (w_in_range) begin
                            if (r_is_sm) begin
                                r_we_sm   <= 1'b1;
                                r_addr_sm <= SM_AW'({r_idx, 2'b00});
                                r_data_sm <= w_word;
                            end else begin
                                r_we_im   <= 1'b1;
                                r_addr_im <= IM_AW'({r_idx, 2'b00});
                                r_data_im <= w_word;
                            end
                        end else begin
                            // Out-of-range words are dropped, never aliased.
                            r_err <= 1'b1;
                        end
                        r_idx <= r_idx + 16'd1;
                        if (w_last) begin
                            r_load_done <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Index was already advanced; equal to count means frame end.
                    r_in_ready <= 1'b1;
                    r_state    <= (r_idx == r_cnt) ? ST_IDLE : ST_DATA;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready              = r_in_ready;
    assign writeAddr_IM          = r_addr_im;
    assign writeData_IM          = r_data_im;
    assign writeEn_IM            = r_we_im;
    assign writeAddr_SM_TB       = r_addr_sm;
    assign writeData_SM_TB       = r_data_sm;
    assign writeEn_SM_TB         = r_we_sm;
    assign Memory_Initialization = r_mem_init;
    assign load_done             = r_load_done;
    assign err_overflow          = r_err;

endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader with small memories so overflow is reachable.
module tb_mem_init_loader;

    localparam int IM_D  = 16;
    localparam int SM_D  = 4;
    localparam int IM_AW = $clog2(IM_D * 4);
    localparam int SM_AW = $clog2(SM_D * 4);

    logic             clk;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [IM_AW-1:0] writeAddr_IM;
    logic [31:0]      writeData_IM;
    logic             writeEn_IM;
    logic [SM_AW-1:0] writeAddr_SM_TB;
    logic [31:0]      writeData_SM_TB;
    logic             writeEn_SM_TB;
    logic             Memory_Initialization;
    logic             load_done;
    logic             err_overflow;

    int checks;
    int failures;

    // Observed events: {in_ready, addr, data} per strobe; {in_ready, weIM, weSM} per done.
    logic [64:0] im_obs[$];
    logic [64:0] sm_obs[$];
    logic [2:0]  done_obs[$];
    int          ready_low_cnt;

    // Reference expectations built from the frame contents.
    logic [64:0] exp_im_q[$];
    logic [64:0] exp_sm_q[$];
    logic [2:0]  exp_done_q[$];
    logic [31:0] frame_words[$];

    mem_init_loader #(
        .IM_DEPTH (IM_D),
        .SM_DEPTH (SM_D)
    ) dut (
        .clk_100MHz            (clk),
        .reset                 (rst_n),
        .in_data               (in_data),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .writeAddr_IM          (writeAddr_IM),
        .writeData_IM          (writeData_IM),
        .writeEn_IM            (writeEn_IM),
        .writeAddr_SM_TB       (writeAddr_SM_TB),
        .writeData_SM_TB       (writeData_SM_TB),
        .writeEn_SM_TB         (writeEn_SM_TB),
        .Memory_Initialization (Memory_Initialization),
        .load_done             (load_done),
        .err_overflow          (err_overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (writeEn_IM)    im_obs.push_back({in_ready, 32'(writeAddr_IM), writeData_IM});
            if (writeEn_SM_TB) sm_obs.push_back({in_ready, 32'(writeAddr_SM_TB), writeData_SM_TB});
            if (load_done)     done_obs.push_back({in_ready, writeEn_IM, writeEn_SM_TB});
            if (!in_ready)     ready_low_cnt++;
        end
    end

    // Driver: optional idle gap, then hold valid until the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout got in_ready=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Sends one load frame and checks strobes, done and overflow against the model.
    task automatic do_load(input logic is_sm, input int n, input int max_gap, input string name);
        int depth;
        logic [64:0] g;
        logic [64:0] e;
        logic [2:0]  gd;
        logic [31:0] w;
        logic        exp_err;
        depth = is_sm ? SM_D : IM_D;
        im_obs.delete();
        sm_obs.delete();
        done_obs.delete();
        for (int i = 0; i < n; i++) begin
            if (i < depth) begin
                if (is_sm) exp_sm_q.push_back({1'b0, 32'(i * 4), frame_words[i]});
                else       exp_im_q.push_back({1'b0, 32'(i * 4), frame_words[i]});
            end
        end
        exp_done_q.push_back({n == 0,
                              !is_sm && n > 0 && (n - 1) < depth,
                              is_sm && n > 0 && (n - 1) < depth});
        exp_err = (n > depth);
        send_byte({6'($urandom), 1'b0, is_sm}, max_gap);
        send_byte(8'(n), max_gap);
        send_byte(8'(n >> 8), max_gap);
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], max_gap);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (im_obs.size() != exp_im_q.size()) begin
            failures++;
            $display("FAIL %s im_strobe_count got=%0d exp=%0d", name, im_obs.size(), exp_im_q.size());
        end
        while (im_obs.size() > 0 && exp_im_q.size() > 0) begin
            g = im_obs.pop_front();
            e = exp_im_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s im_write got=%h exp=%h", name, g, e);
            end
        end
        checks++;
        if (sm_obs.size() != exp_sm_q.size()) begin
            failures++;
            $display("FAIL %s sm_strobe_count got=%0d exp=%0d", name, sm_obs.size(), exp_sm_q.size());
        end
        while (sm_obs.size() > 0 && exp_sm_q.size() > 0) begin
            g = sm_obs.pop_front();
            e = exp_sm_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s sm_write got=%h exp=%h", name, g, e);
            end
        end
        checks++;
        if (done_obs.size() != 1) begin
            failures++;
            $display("FAIL %s load_done_count got=%0d exp=1", name, done_obs.size());
        end else begin
            gd = done_obs.pop_front();
            checks++;
            if (gd !== exp_done_q[0]) begin
                failures++;
                $display("FAIL %s load_done_ctx got=%b exp=%b", name, gd, exp_done_q[0]);
            end
        end
        checks++;
        if (err_overflow !== exp_err) begin
            failures++;
            $display("FAIL %s err_overflow got=%b exp=%b", name, err_overflow, exp_err);
        end
        checks++;
        if (Memory_Initialization !== 1'b1) begin
            failures++;
            $display("FAIL %s mem_init got=%b exp=1", name, Memory_Initialization);
        end
        im_obs.delete();
        sm_obs.delete();
        done_obs.delete();
        exp_im_q.delete();
        exp_sm_q.delete();
        exp_done_q.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, writeEn_IM, writeEn_SM_TB, load_done, err_overflow, Memory_Initialization} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000001",
                     {in_ready, writeEn_IM, writeEn_SM_TB, load_done, err_overflow, Memory_Initialization});
        end
        checks++;
        if ({writeAddr_IM, writeData_IM, writeAddr_SM_TB, writeData_SM_TB} !== '0) begin
            failures++;
            $display("FAIL reset_addr_data got=%h exp=0",
                     {writeAddr_IM, writeData_IM, writeAddr_SM_TB, writeData_SM_TB});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_im_basic();
        frame_words.delete();
        frame_words.push_back(32'h00500013);
        frame_words.push_back(32'h00A00093);
        do_load(1'b0, 2, 0, "im_basic");
    endtask

    task automatic test_sm_basic();
        frame_words.delete();
        frame_words.push_back(32'hDEADBEEF);
        do_load(1'b1, 1, 0, "sm_basic");
    endtask

    task automatic test_run_halt();
        send_byte({6'($urandom), 2'b10}, 0);
        checks++;
        if (Memory_Initialization !== 1'b0) begin
            failures++;
            $display("FAIL run_mem_init got=%b exp=0", Memory_Initialization);
        end
        send_byte({6'($urandom), 2'b11}, 0);
        checks++;
        if (Memory_Initialization !== 1'b1) begin
            failures++;
            $display("FAIL halt_mem_init got=%b exp=1", Memory_Initialization);
        end
    endtask

    task automatic test_sm_overflow();
        frame_words.delete();
        for (int i = 0; i < 5; i++) frame_words.push_back($urandom);
        do_load(1'b1, 5, 0, "sm_overflow");
    endtask

    task automatic test_zero_count();
        done_obs.delete();
        im_obs.delete();
        sm_obs.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_pulse got=%b exp=1", load_done);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_width got=%b exp=0", load_done);
        end
        checks++;
        if (im_obs.size() + sm_obs.size() != 0) begin
            failures++;
            $display("FAIL zero_no_strobe got=%0d exp=0", im_obs.size() + sm_obs.size());
        end
        // The next byte must be taken as a header.
        send_byte(8'h02, 0);
        checks++;
        if (Memory_Initialization !== 1'b0) begin
            failures++;
            $display("FAIL zero_next_header got=%b exp=0", Memory_Initialization);
        end
        send_byte(8'h03, 0);
        done_obs.delete();
    endtask

    task automatic test_gapped();
        logic [31:0] saved[$];
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
        saved = frame_words;
        do_load(1'b0, 3, 0, "im_nogap");
        frame_words = saved;
        ready_low_cnt = 0;
        do_load(1'b0, 3, 3, "im_gapped");
        checks++;
        if (ready_low_cnt != 3) begin
            failures++;
            $display("FAIL gapped_ready_low got=%0d exp=3", ready_low_cnt);
        end
    endtask

    task automatic test_random();
        logic is_sm;
        int   n;
        for (int f = 0; f < 8; f++) begin
            is_sm = 1'($urandom);
            n = is_sm ? int'($urandom_range(6, 0)) : int'($urandom_range(18, 0));
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            do_load(is_sm, n, int'($urandom_range(3, 0)), "random");
        end
    endtask

    task automatic test_mid_reset();
        // Leave the loader running with overflow flagged, then cut a frame short.
        frame_words.delete();
        for (int i = 0; i < 5; i++) frame_words.push_back($urandom);
        do_load(1'b1, 5, 0, "pre_reset_ovf");
        send_byte(8'h02, 0);
        im_obs.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, Memory_Initialization, err_overflow, writeEn_IM} !== 4'b0100) begin
            failures++;
            $display("FAIL mid_reset_flags got=%b exp=0100",
                     {in_ready, Memory_Initialization, err_overflow, writeEn_IM});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (im_obs.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_no_strobe got=%0d exp=0", im_obs.size());
        end
        frame_words.delete();
        frame_words.push_back(32'h12345678);
        do_load(1'b0, 1, 0, "post_reset");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        ready_low_cnt = 0;
        test_reset();
        test_im_basic();
        test_sm_basic();
        test_run_halt();
        test_sm_overflow();
        test_zero_count();
        test_gapped();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
